// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module : cpu_pkg
// Brief  : Shared widths, opcode constants and IF/ID field layout.
// Rev    : 1.0
// ============================================================================
package cpu_pkg;

  localparam int unsigned PC_W    = 16;
  localparam int unsigned INSTR_W = 32;
  localparam int unsigned BCNT_W  = 16;

  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;

  localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [2:0] F3_ADD     = 3'b000;
  localparam logic [2:0] F3_SUB     = 3'b000;
  localparam logic [2:0] F3_AND     = 3'b111;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_BEQ     = 3'b000;
  localparam logic [6:0] F7_ADD     = 7'b0000000;
  localparam logic [6:0] F7_SUB     = 7'b0100000;

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
    logic               valid;
    logic               err;
  } if_id_t;

  localparam if_id_t IFID_BUBBLE = '{pc: '0, instr: NOP_INSTR, valid: 1'b0, err: 1'b0};

endpackage
`default_nettype wire

// File: rtl/if_imem.sv
`default_nettype none
// ============================================================================
// Module : if_imem
// Brief  : Instruction memory, async read port with range flag, sync write.
// Rev    : 1.0
// ============================================================================
module if_imem
  import cpu_pkg::*;
#(
  parameter int unsigned DEPTH = 64
) (
  input  logic               clk,
  input  logic [PC_W-1:0]    raddr_i,
  output logic [INSTR_W-1:0] rdata_o,
  output logic               rerr_o,
  input  logic               we_i,
  input  logic [PC_W-1:0]    waddr_i,
  input  logic [INSTR_W-1:0] wdata_i
);

  localparam int unsigned     AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PC_W-1:0] DEPTH_PC = PC_W'(DEPTH);

  logic [INSTR_W-1:0] mem [DEPTH];
  logic               r_in_range;
  logic               w_in_range;

  assign r_in_range = (raddr_i < DEPTH_PC);
  assign w_in_range = (waddr_i < DEPTH_PC);

  // Read is combinational, so a same-edge write is seen only on the next fetch.
  assign rdata_o = r_in_range ? mem[raddr_i[AW-1:0]] : NOP_INSTR;
  assign rerr_o  = ~r_in_range;

  always_ff @(posedge clk) begin
    if (we_i && w_in_range) begin
      mem[waddr_i[AW-1:0]] <= wdata_i;
    end
  end

endmodule
`default_nettype wire

// File: rtl/if_stage.sv
`default_nettype none
// ============================================================================
// Module : if_stage
// Brief  : Fetch stage: PC, instruction memory, IF/ID register, bubble counter.
// Rev    : 1.0
// ============================================================================
module if_stage
  import cpu_pkg::*;
#(
  parameter int unsigned     IMEM_DEPTH = 64,
  parameter logic [PC_W-1:0] RESET_PC   = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               stall_i,
  input  logic               flush_i,
  input  logic [PC_W-1:0]    target_i,
  input  logic               imem_we_i,
  input  logic [PC_W-1:0]    imem_waddr_i,
  input  logic [INSTR_W-1:0] imem_wdata_i,
  output logic [PC_W-1:0]    pc_o,
  output logic [INSTR_W-1:0] instr_o,
  output logic               valid_o,
  output logic [PC_W-1:0]    fetch_pc_o,
  output logic               fetch_err_o,
  output logic [BCNT_W-1:0]  bubble_cnt_o
);

  logic [PC_W-1:0]    pc_q, pc_d;
  if_id_t             ifid_q, ifid_d;
  logic [BCNT_W-1:0]  bubble_cnt_q, bubble_cnt_d;
  logic [INSTR_W-1:0] imem_rdata;
  logic               imem_rerr;

  if_imem #(
    .DEPTH (IMEM_DEPTH)
  ) u_imem (
    .clk     (clk),
    .raddr_i (pc_q),
    .rdata_o (imem_rdata),
    .rerr_o  (imem_rerr),
    .we_i    (imem_we_i),
    .waddr_i (imem_waddr_i),
    .wdata_i (imem_wdata_i)
  );

  // Flush outranks stall so a branch redirect is never dropped.
  always_comb begin
    pc_d         = pc_q;
    ifid_d       = ifid_q;
    bubble_cnt_d = bubble_cnt_q;
    if (flush_i) begin
      pc_d   = target_i;
      ifid_d = IFID_BUBBLE;
    end else if (!stall_i) begin
      pc_d         = pc_q + 1'b1;
      ifid_d.pc    = pc_q;
      ifid_d.instr = imem_rdata;
      ifid_d.valid = 1'b1;
      ifid_d.err   = imem_rerr;
    end
    if ((flush_i || !stall_i) && !ifid_d.valid && (bubble_cnt_q != '1)) begin
      bubble_cnt_d = bubble_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q         <= RESET_PC;
      ifid_q       <= IFID_BUBBLE;
      bubble_cnt_q <= '0;
    end else begin
      pc_q         <= pc_d;
      ifid_q       <= ifid_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign pc_o         = ifid_q.pc;
  assign instr_o      = ifid_q.instr;
  assign valid_o      = ifid_q.valid;
  assign fetch_err_o  = ifid_q.err;
  assign fetch_pc_o   = pc_q;
  assign bubble_cnt_o = bubble_cnt_q;

endmodule
`default_nettype wire
